decode_dispatch_queue: RTL and testbench
========================================

Name: decode_dispatch_queue

Overview:
- Buffers decoded instructions between the decode stage and the dispatch stage.
- Each cycle it accepts one entry carrying a control_decode_io bundle, rd and funct7_5.
- On enqueue it resolves alu_op/funct3/op_5_xor_6/funct7_5 into a 4-bit alu_control, so decode timing is untouched.
- It presents the oldest entry to dispatch as a control_dispatch_io bundle with a valid/ready handshake, and absorbs dispatch back-pressure without stalling decode for up to DEPTH entries.

Parameters:
- DEPTH, 4, number of queue entries; must be a power of two, at least 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, never overridden.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous discard of all entries (branch mispredict / redirect)
- in_valid  input  1  decode presents an entry
- in_ready  output  1  queue can accept an entry this cycle
- dec_ctrl  control_decode_io.out  bundle  decoded control signals of the entry
- in_rd  input  5  destination register
- in_funct7_5  input  1  instr[30]
- out_valid  output  1  head entry valid
- out_ready  input  1  dispatch consumes the head this cycle
- disp_ctrl  control_dispatch_io.in  bundle  head entry control, with alu_control resolved
- out_dispatch_unit  output  4  head entry target unit
- out_rd  output  5  head entry destination register
- count  output  PTR_W+1  occupied entries

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr, rd_ptr and count go to 0.
  - in_ready=1 and out_valid=0.
  - All disp_ctrl fields, out_dispatch_unit and out_rd read 0.
  - Reset mid-operation drops every entry; no partial state survives.
- Handshake signals:
  - enq = in_valid & in_ready, where in_ready = (count != DEPTH).
  - deq = out_valid & out_ready, where out_valid = (count != 0).
- No bypass path:
  - An entry written in cycle N is visible on the outputs from cycle N+1.
  - Minimum latency is 1 cycle.
  - When full, in_ready stays 0 even if deq occurs in the same cycle.
- Simultaneous enq and deq with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH using natural PTR_W overflow.
- Empty queue: disp_ctrl outputs, out_dispatch_unit and out_rd are forced to 0, so reg_write, fpu_reg_write and jump are never asserted from stale data. in_ready stays 1.
- Head field mapping: disp_ctrl.{jump, rs_fpu, alu_src, store_src, reg_write, fpu_reg_write, result_src, alu_control} come from the head entry; out_dispatch_unit comes from the entry's dispatch_unit.
- Flush:
  - Clears both pointers and count on the next edge.
  - Takes priority over an enq or deq in the same cycle; the incoming entry is dropped.
  - out_valid=0 in the cycle after flush.
- alu_control, resolved at enqueue and stored in the entry:
  - alu_op=00 -> ADD.
  - alu_op=01 -> SUB.
  - alu_op=11 -> PASSB.
  - alu_op=10, by funct3:
    - 000 -> SUB if (op_5_xor_6 & funct7_5), else ADD.
    - 001 -> SLL.
    - 010 -> SLT.
    - 011 -> SLTU.
    - 100 -> XOR.
    - 101 -> SRA if funct7_5, else SRL.
    - 110 -> OR.
    - 111 -> AND.
- Entry storage:
  - Entry width = 1+3+4+1+1+1+1+4+4+5 = 25 bits.
  - Storage is a flop array with no reset on the data; the outputs are gated by out_valid.
- count is always in the range 0..DEPTH; any other value is a design error (assertion).

Decomposition:
- Package dispatch_pkg holds:
  - alu_ctrl_e: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9, PASSB=10.
  - alu_op encodings ALU_OP_ADD/SUB/FUNCT/PASSB.
  - The dq_entry_t packed struct.
- One combinational sub-module, alu_decoder, maps (alu_op, funct3, op_5_xor_6, funct7_5) to alu_ctrl_e. It is instantiated at the enqueue side.

Test Plan:
- Reset then idle: hold rst_n=0, release -> in_ready=1, out_valid=0, count=0, disp_ctrl.reg_write=0.
- Fill and stall: push 4 entries with out_ready=0 -> count=4, in_ready=0; a 5th in_valid is not accepted and the head stays entry 0 (rd=1).
- Streaming: in_valid=1 and out_ready=1 continuously for 10 cycles after a first push -> count stays 1, rd sequence out = in sequence delayed 1 cycle, pointers wrap past 3 with no loss.
- ALU resolution:
  - alu_op=10, funct3=000, op_5_xor_6=1, funct7_5=1 -> alu_control=1 (SUB).
  - Same with op_5_xor_6=0 -> 0 (ADD).
  - funct3=101, funct7_5=1 -> 9 (SRA).
  - alu_op=11 -> 10 (PASSB).
- Flush priority: count=3, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, and the flushed-cycle entry never appears.
- Async reset mid-stream: count=2, pull rst_n low between clock edges -> out_valid and count drop to 0 immediately, before the next edge.

Source files
------------

// File: rtl/dispatch_pkg.sv
// rtl/dispatch_pkg.sv - shared types for the decode-to-dispatch queue
package dispatch_pkg;

    typedef enum logic [3:0] {
        ADD   = 4'd0,
        SUB   = 4'd1,
        AND   = 4'd2,
        OR    = 4'd3,
        XOR   = 4'd4,
        SLT   = 4'd5,
        SLTU  = 4'd6,
        SLL   = 4'd7,
        SRL   = 4'd8,
        SRA   = 4'd9,
        PASSB = 4'd10
    } alu_ctrl_e;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_PASSB = 2'b11;

    // One queue slot; alu_control is already resolved when stored
    typedef struct packed {
        logic       jump;
        logic [2:0] rs_fpu;
        logic [3:0] alu_src;
        logic       store_src;
        logic       reg_write;
        logic       fpu_reg_write;
        logic       result_src;
        alu_ctrl_e  alu_control;
        logic [3:0] dispatch_unit;
        logic [4:0] rd;
    } dq_entry_t;

endpackage

// File: rtl/control_decode_io.sv
// rtl/control_decode_io.sv - decoded control bundle produced by the decode stage
interface control_decode_io;
    logic       jump;
    logic [2:0] rs_fpu;
    logic [3:0] alu_src;
    logic       store_src;
    logic       reg_write;
    logic       fpu_reg_write;
    logic       result_src;
    logic [1:0] alu_op;
    logic [2:0] funct3;
    logic       op_5_xor_6;
    logic [3:0] dispatch_unit;

    // Decode's outputs as seen by a consumer of the bundle
    modport out (
        input jump, rs_fpu, alu_src, store_src, reg_write, fpu_reg_write,
              result_src, alu_op, funct3, op_5_xor_6, dispatch_unit
    );
endinterface

// File: rtl/control_dispatch_io.sv
// rtl/control_dispatch_io.sv - control bundle delivered into the dispatch stage
interface control_dispatch_io;
    logic       jump;
    logic [2:0] rs_fpu;
    logic [3:0] alu_src;
    logic       store_src;
    logic       reg_write;
    logic       fpu_reg_write;
    logic       result_src;
    logic [3:0] alu_control;

    // Dispatch's inputs, driven by the producer holding this modport
    modport in (
        output jump, rs_fpu, alu_src, store_src, reg_write, fpu_reg_write,
               result_src, alu_control
    );
endinterface

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - resolves alu_op/funct3/funct7 into an ALU control code
module alu_decoder
    import dispatch_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op_5_xor_6,
    input  logic       funct7_5,
    output alu_ctrl_e  alu_control
);

    // Pure lookup; SUB for funct3=000 only for R-type (op_5_xor_6) with instr[30]
    always_comb begin
        alu_control = ADD;
        case (alu_op)
            ALU_OP_ADD:   alu_control = ADD;
            ALU_OP_SUB:   alu_control = SUB;
            ALU_OP_PASSB: alu_control = PASSB;
            ALU_OP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op_5_xor_6 & funct7_5) ? SUB : ADD;
                    3'b001:  alu_control = SLL;
                    3'b010:  alu_control = SLT;
                    3'b011:  alu_control = SLTU;
                    3'b100:  alu_control = XOR;
                    3'b101:  alu_control = funct7_5 ? SRA : SRL;
                    3'b110:  alu_control = OR;
                    default: alu_control = AND;
                endcase
            end
            default: alu_control = ADD;
        endcase
    end

endmodule

// File: rtl/decode_dispatch_queue.sv
// rtl/decode_dispatch_queue.sv - DEPTH-entry FIFO between decode and dispatch
module decode_dispatch_queue
    import dispatch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    control_decode_io.out      dec_ctrl,
    input  logic [4:0]         in_rd,
    input  logic               in_funct7_5,
    output logic               out_valid,
    input  logic               out_ready,
    control_dispatch_io.in     disp_ctrl,
    output logic [3:0]         out_dispatch_unit,
    output logic [4:0]         out_rd,
    output logic [PTR_W:0]     count
);

    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_q;
    logic             enq;
    logic             deq;
    alu_ctrl_e        enq_alu;
    dq_entry_t        enq_entry;
    dq_entry_t        head;
    dq_entry_t        shown;
    dq_entry_t        mem [DEPTH];

    // No bypass: in_ready depends only on stored occupancy, so a full queue
    // refuses input even while the head is being consumed
    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    // A flush cycle neither writes nor consumes anything
    assign enq = in_valid & in_ready & ~flush;
    assign deq = out_valid & out_ready & ~flush;

    alu_decoder u_alu_decoder (
        .alu_op      (dec_ctrl.alu_op),
        .funct3      (dec_ctrl.funct3),
        .op_5_xor_6  (dec_ctrl.op_5_xor_6),
        .funct7_5    (in_funct7_5),
        .alu_control (enq_alu)
    );

    // Pack the incoming entry with its ALU control already resolved
    always_comb begin
        enq_entry               = '0;
        enq_entry.jump          = dec_ctrl.jump;
        enq_entry.rs_fpu        = dec_ctrl.rs_fpu;
        enq_entry.alu_src       = dec_ctrl.alu_src;
        enq_entry.store_src     = dec_ctrl.store_src;
        enq_entry.reg_write     = dec_ctrl.reg_write;
        enq_entry.fpu_reg_write = dec_ctrl.fpu_reg_write;
        enq_entry.result_src    = dec_ctrl.result_src;
        enq_entry.alu_control   = enq_alu;
        enq_entry.dispatch_unit = dec_ctrl.dispatch_unit;
        enq_entry.rd            = in_rd;
    end

    // Data array carries no reset; validity comes solely from count
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= enq_entry;
        end
    end

    // Pointer and occupancy tracking; flush wins over any enq/deq
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Gate the head so stale array contents never reach dispatch
    always_comb begin
        head  = mem[rd_ptr];
        shown = out_valid ? head : '0;
    end

    assign disp_ctrl.jump          = shown.jump;
    assign disp_ctrl.rs_fpu        = shown.rs_fpu;
    assign disp_ctrl.alu_src       = shown.alu_src;
    assign disp_ctrl.store_src     = shown.store_src;
    assign disp_ctrl.reg_write     = shown.reg_write;
    assign disp_ctrl.fpu_reg_write = shown.fpu_reg_write;
    assign disp_ctrl.result_src    = shown.result_src;
    assign disp_ctrl.alu_control   = shown.alu_control;
    assign out_dispatch_unit       = shown.dispatch_unit;
    assign out_rd                  = shown.rd;

    count_in_range: assert property (@(posedge clk) disable iff (!rst_n) count_q <= FULL);

endmodule

// File: tb/tb_decode_dispatch_queue.sv
// tb/tb_decode_dispatch_queue.sv - directed self-checking bench for decode_dispatch_queue
module tb_decode_dispatch_queue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_rd;
    logic       in_funct7_5;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_dispatch_unit;
    logic [4:0] out_rd;
    logic [2:0] count;

    int n_vec = 0;
    int n_err = 0;

    control_decode_io   dec_if ();
    control_dispatch_io disp_if ();

    decode_dispatch_queue #(.DEPTH(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .dec_ctrl          (dec_if),
        .in_rd             (in_rd),
        .in_funct7_5       (in_funct7_5),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .disp_ctrl         (disp_if),
        .out_dispatch_unit (out_dispatch_unit),
        .out_rd            (out_rd),
        .count             (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_entry(input logic [4:0] rd, input logic [1:0] aop, input logic [2:0] f3,
                             input logic o56, input logic f75);
        in_rd                = rd;
        in_funct7_5          = f75;
        dec_if.alu_op        = aop;
        dec_if.funct3        = f3;
        dec_if.op_5_xor_6    = o56;
        dec_if.reg_write     = 1'b1;
        dec_if.jump          = 1'b1;
        dec_if.dispatch_unit = rd[3:0];
    endtask

    logic [1:0] v_aop [7] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b10, 2'b10, 2'b10};
    logic [2:0] v_f3  [7] = '{3'b000, 3'b000, 3'b101, 3'b000, 3'b101, 3'b010, 3'b111};
    logic       v_o56 [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       v_f75 [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] v_exp [7] = '{4'd1, 4'd0, 4'd9, 4'd10, 4'd8, 4'd5, 4'd2};

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dec_if.rs_fpu        = 3'd0;
        dec_if.alu_src       = 4'd0;
        dec_if.store_src     = 1'b0;
        dec_if.fpu_reg_write = 1'b0;
        dec_if.result_src    = 1'b0;
        set_entry(5'd0, 2'b00, 3'd0, 1'b0, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Reset then idle
        chk("rst_in_ready", 8'(in_ready), 8'd1);
        chk("rst_out_valid", 8'(out_valid), 8'd0);
        chk("rst_count", 8'(count), 8'd0);
        chk("rst_reg_write", 8'(disp_if.reg_write), 8'd0);
        chk("rst_out_rd", 8'(out_rd), 8'd0);

        // Fill and stall
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            set_entry(5'(i), 2'b00, 3'd0, 1'b0, 1'b0);
            step();
        end
        chk("full_count", 8'(count), 8'd4);
        chk("full_in_ready", 8'(in_ready), 8'd0);
        chk("full_head_rd", 8'(out_rd), 8'd1);
        set_entry(5'd5, 2'b00, 3'd0, 1'b0, 1'b0);
        step();
        chk("full_5th_count", 8'(count), 8'd4);
        chk("full_5th_head_rd", 8'(out_rd), 8'd1);
        chk("full_head_unit", 8'(out_dispatch_unit), 8'd1);
        chk("full_head_reg_write", 8'(disp_if.reg_write), 8'd1);

        // Drain in order
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_rd", 8'(out_rd), 8'(i));
            step();
        end
        chk("drain_count", 8'(count), 8'd0);
        chk("drain_out_valid", 8'(out_valid), 8'd0);
        chk("empty_out_rd", 8'(out_rd), 8'd0);
        chk("empty_reg_write", 8'(disp_if.reg_write), 8'd0);
        chk("empty_jump", 8'(disp_if.jump), 8'd0);

        // Streaming with pointer wrap
        in_valid = 1'b1;
        set_entry(5'd10, 2'b00, 3'd0, 1'b0, 1'b0);
        step();
        for (int k = 0; k < 10; k++) begin
            set_entry(5'(11 + k), 2'b00, 3'd0, 1'b0, 1'b0);
            chk("stream_rd", 8'(out_rd), 8'(10 + k));
            chk("stream_count", 8'(count), 8'd1);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("stream_end_count", 8'(count), 8'd0);

        // ALU resolution, one entry at a time
        for (int v = 0; v < 7; v++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            set_entry(5'd7, v_aop[v], v_f3[v], v_o56[v], v_f75[v]);
            step();
            in_valid = 1'b0;
            chk("alu_control", 8'(disp_if.alu_control), 8'(v_exp[v]));
            out_ready = 1'b1;
            step();
        end
        chk("alu_end_count", 8'(count), 8'd0);

        // Flush priority
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 21; i <= 23; i++) begin
            set_entry(5'(i), 2'b00, 3'd0, 1'b0, 1'b0);
            step();
        end
        chk("preflush_count", 8'(count), 8'd3);
        flush     = 1'b1;
        out_ready = 1'b1;
        set_entry(5'd24, 2'b00, 3'd0, 1'b0, 1'b0);
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("flush_count", 8'(count), 8'd0);
        chk("flush_out_valid", 8'(out_valid), 8'd0);
        chk("flush_out_rd", 8'(out_rd), 8'd0);
        in_valid = 1'b1;
        set_entry(5'd25, 2'b00, 3'd0, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        chk("postflush_head_rd", 8'(out_rd), 8'd25);
        chk("postflush_count", 8'(count), 8'd1);

        // Asynchronous reset mid-stream
        in_valid = 1'b1;
        set_entry(5'd26, 2'b00, 3'd0, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        chk("prereset_count", 8'(count), 8'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 8'(out_valid), 8'd0);
        chk("async_count", 8'(count), 8'd0);
        chk("async_out_rd", 8'(out_rd), 8'd0);
        chk("async_in_ready", 8'(in_ready), 8'd1);
        step();
        rst_n = 1'b1;
        step();
        chk("after_reset_count", 8'(count), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
